// File: rtl/elevator_pkg.sv
// Shared scheduler/car-controller definitions: floor code width, direction and FSM state encodings.
// Constants only, so no latency and no backpressure.
// Floor code 0 is reserved for "no floor".
package elevator_pkg;

    localparam int FLOOR_W = 3;
    localparam logic [FLOOR_W-1:0] FLOOR_NONE = '0;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SELECT    = 2'd1;
    localparam logic [1:0] S_ISSUE     = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = S_IDLE,
        ST_SELECT    = S_SELECT,
        ST_ISSUE     = S_ISSUE,
        ST_WAIT_DONE = S_WAIT_DONE
    } state_e;

endpackage

// File: rtl/elevator_scan_pick.sv
// SCAN target chooser: current floor, else nearest ahead, else nearest behind (with reversal).
// Purely combinational, zero latency; no handshake.
// An out-of-range current floor falls back to the lowest pending floor heading up.
module elevator_scan_pick #(
    parameter int NUM_FLOORS = 7,
    parameter int FLOOR_W    = 3
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  dir_up,
    output logic [FLOOR_W-1:0]    pick_floor,
    output logic                  pick_found,
    output logic                  flip_dir
);
    import elevator_pkg::*;

    int                 cur_int;
    logic               cur_valid;
    logic               here_hit;
    logic               up_found, dn_found, low_found;
    logic [FLOOR_W-1:0] up_floor, dn_floor, low_floor;

    always_comb begin
        cur_int   = int'(cur_floor);
        cur_valid = (cur_int >= 1) && (cur_int <= NUM_FLOORS);
        here_hit  = 1'b0;
        up_found  = 1'b0;
        up_floor  = '0;
        low_found = 1'b0;
        low_floor = '0;
        dn_found  = 1'b0;
        dn_floor  = '0;
        // Descending scan: last hit is the lowest pending / lowest floor above the car.
        for (int f = NUM_FLOORS; f >= 1; f--) begin
            if (pending[f-1]) begin
                low_found = 1'b1;
                low_floor = FLOOR_W'(f);
                if (f == cur_int)
                    here_hit = 1'b1;
                if (f > cur_int) begin
                    up_found = 1'b1;
                    up_floor = FLOOR_W'(f);
                end
            end
        end
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (pending[f-1] && (f < cur_int)) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(f);
            end
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_floor = FLOOR_W'(FLOOR_NONE);
        flip_dir   = 1'b0;
        if (!cur_valid) begin
            pick_found = low_found;
            pick_floor = low_floor;
            flip_dir   = low_found && (dir_up != DIR_UP);
        end else if (here_hit) begin
            pick_found = 1'b1;
            pick_floor = cur_floor;
        end else if (dir_up ? up_found : dn_found) begin
            pick_found = 1'b1;
            pick_floor = dir_up ? up_floor : dn_floor;
        end else if (dir_up ? dn_found : up_found) begin
            pick_found = 1'b1;
            pick_floor = dir_up ? dn_floor : up_floor;
            flip_dir   = 1'b1;
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Holds floor calls and issues one SCAN-ordered target at a time to the car controller.
// Latency: pending visible 1 edge after a call, target_valid 2 edges after pending is non-zero.
// Backpressure: target held stable until target_ready; calls stay pending until service_done.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS = 7,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W,
    parameter int TIMEOUT    = 63
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  target_ready,
    input  logic                  service_done,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy,
    output logic                  timeout_err
);
    import elevator_pkg::*;

    localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]            state;
    logic [FLOOR_W-1:0]    tgt;
    logic [WD_W-1:0]       wdog;
    logic [NUM_FLOORS-1:0] clr;
    logic [FLOOR_W-1:0]    pick_floor;
    logic                  pick_found;
    logic                  flip_dir;

    elevator_scan_pick #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_pick (
        .pending    (pending),
        .cur_floor  (cur_floor),
        .dir_up     (dir_up),
        .pick_floor (pick_floor),
        .pick_found (pick_found),
        .flip_dir   (flip_dir)
    );

    always_comb begin
        clr = '0;
        if ((state == S_WAIT_DONE) && service_done) begin
            for (int f = 1; f <= NUM_FLOORS; f++) begin
                if (tgt == FLOOR_W'(f))
                    clr[f-1] = 1'b1;
            end
        end
    end

    assign target_valid = (state == S_ISSUE);
    assign target_floor = target_valid ? tgt : FLOOR_W'(FLOOR_NONE);
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pending     <= '0;
            tgt         <= FLOOR_W'(FLOOR_NONE);
            dir_up      <= DIR_UP;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            // A call landing on the floor being cleared wins: OR is applied after the mask.
            pending     <= (pending & ~clr) | call;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pending != '0)
                        state <= S_SELECT;
                end
                S_SELECT: begin
                    if (pick_found) begin
                        tgt   <= pick_floor;
                        state <= S_ISSUE;
                        if (flip_dir)
                            dir_up <= ~dir_up;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (target_ready) begin
                        wdog  <= '0;
                        state <= S_WAIT_DONE;
                    end
                end
                default: begin
                    if (service_done) begin
                        wdog  <= '0;
                        state <= S_IDLE;
                    end else if (int'(wdog) + 1 >= TIMEOUT) begin
                        wdog        <= '0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: reset, single call, SCAN order, priority,
// set/clear collision, watchdog expiry and reset during ISSUE.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] call;
    logic [2:0] cur_floor;
    logic       target_ready;
    logic       service_done;
    logic [2:0] target_floor;
    logic       target_valid;
    logic       dir_up;
    logic [6:0] pending;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    elevator_call_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .call         (call),
        .cur_floor    (cur_floor),
        .target_ready (target_ready),
        .service_done (service_done),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .dir_up       (dir_up),
        .pending      (pending),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered in IDLE with pending set; leaves in IDLE after service_done.
    task automatic serve(input string tag, input logic [2:0] fl, input logic dir);
        tick();
        tick();
        chk({tag, "_valid"}, 32'(target_valid), 32'd1);
        chk({tag, "_floor"}, 32'(target_floor), 32'(fl));
        chk({tag, "_dir"}, 32'(dir_up), 32'(dir));
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        cur_floor    = fl;
        service_done = 1'b1;
        tick();
        service_done = 1'b0;
    endtask

    initial begin
        logic seen;
        rst          = 1'b1;
        call         = 7'b0;
        cur_floor    = 3'd1;
        target_ready = 1'b0;
        service_done = 1'b0;
        tick();
        tick();
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_tfloor", 32'(target_floor), 32'd0);
        chk("rst_tvalid", 32'(target_valid), 32'd0);
        chk("rst_dir", 32'(dir_up), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick();

        // Single call to floor 5 from floor 1: driven after edge 0, valid after edge 3.
        call = 7'b0010000;
        tick();
        call = 7'b0;
        chk("single_pending", 32'(pending), 32'h10);
        chk("single_busy_idle", 32'(busy), 32'd0);
        tick();
        chk("single_busy_sel", 32'(busy), 32'd1);
        chk("single_valid_sel", 32'(target_valid), 32'd0);
        tick();
        chk("single_valid", 32'(target_valid), 32'd1);
        chk("single_floor", 32'(target_floor), 32'd5);
        tick();
        chk("single_hold_floor", 32'(target_floor), 32'd5);
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        chk("single_hs_valid", 32'(target_valid), 32'd0);
        chk("single_hs_floor", 32'(target_floor), 32'd0);
        chk("single_hs_busy", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        service_done = 1'b1;
        tick();
        service_done = 1'b0;
        chk("single_done_pending", 32'(pending), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);

        // SCAN from floor 3 heading up with calls {2,4,6}: 4, 6, then reverse to 2.
        cur_floor = 3'd3;
        call = 7'b0101010;
        tick();
        call = 7'b0;
        serve("scan_a", 3'd4, 1'b1);
        serve("scan_b", 3'd6, 1'b1);
        serve("scan_c", 3'd2, 1'b0);
        chk("scan_pending", 32'(pending), 32'd0);

        // Current-floor priority at 4 heading down with {4,7}: 4 first, then reverse to 7.
        cur_floor = 3'd4;
        call = 7'b1001000;
        tick();
        call = 7'b0;
        serve("prio_a", 3'd4, 1'b0);
        serve("prio_b", 3'd7, 1'b1);
        chk("prio_pending", 32'(pending), 32'd0);

        // Call for floor 5 arriving in the same cycle as its service_done.
        call = 7'b0010000;
        tick();
        call = 7'b0;
        tick();
        tick();
        chk("coll_floor", 32'(target_floor), 32'd5);
        chk("coll_dir", 32'(dir_up), 32'd0);
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        service_done = 1'b1;
        call = 7'b0010000;
        tick();
        service_done = 1'b0;
        call = 7'b0;
        chk("coll_pending", 32'(pending), 32'h10);
        chk("coll_busy", 32'(busy), 32'd0);
        serve("coll_reissue", 3'd5, 1'b0);
        chk("coll_cleared", 32'(pending), 32'd0);

        // Watchdog: floor 3 issued from floor 5, service_done withheld.
        call = 7'b0000100;
        tick();
        call = 7'b0;
        tick();
        tick();
        chk("wd_floor", 32'(target_floor), 32'd3);
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 62; i++) begin
            tick();
            if (timeout_err) seen = 1'b1;
        end
        chk("wd_early", 32'(seen), 32'd0);
        tick();
        chk("wd_pulse", 32'(timeout_err), 32'd1);
        chk("wd_pending", 32'(pending), 32'h04);
        chk("wd_idle", 32'(busy), 32'd0);
        tick();
        chk("wd_pulse_end", 32'(timeout_err), 32'd0);
        tick();
        chk("wd_reissue_valid", 32'(target_valid), 32'd1);
        chk("wd_reissue_floor", 32'(target_floor), 32'd3);

        // Reset while ISSUE is presenting floor 3, with a simultaneous call.
        rst = 1'b1;
        call = 7'b1000000;
        tick();
        rst = 1'b0;
        call = 7'b0;
        chk("mrst_pending", 32'(pending), 32'd0);
        chk("mrst_valid", 32'(target_valid), 32'd0);
        chk("mrst_floor", 32'(target_floor), 32'd0);
        chk("mrst_dir", 32'(dir_up), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_terr", 32'(timeout_err), 32'd0);
        tick();
        chk("mrst_call_dropped", 32'(pending), 32'd0);
        chk("mrst_still_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Collects floor calls from hall and car buttons and dispatches one target floor at a time to the elevator car controller. Uses a SCAN (elevator) policy: the car keeps its travel direction while calls remain ahead, then reverses. Sits between the button-sampling logic and the car controller's 3-bit floor request input. Holds each call pending until the controller reports that the floor has been served.

## Interface
- `NUM_FLOORS`, default 7: served floors, encoded 1..NUM_FLOORS; code 0 means "no floor".
- `FLOOR_W`, default 3: floor code width; must satisfy 2^FLOOR_W > NUM_FLOORS.
- `TIMEOUT`, default 63: maximum number of WAIT_DONE cycles before the scheduler abandons the issued target.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `call` in NUM_FLOORS: bit i-1 is a one-cycle call pulse for floor i. Multiple bits may be high in the same cycle.
- `cur_floor` in FLOOR_W: car's current floor, as reported by the controller.
- `target_ready` in 1: controller is idle and can accept a target.
- `service_done` in 1: one-cycle pulse; the car has opened and closed its door at the issued target.
- `target_floor` out FLOOR_W: floor being issued; 0 when `target_valid` is low.
- `target_valid` out 1: `target_floor` is valid.
- `dir_up` out 1: current SCAN direction (1 = up).
- `pending` out NUM_FLOORS: registered call set.
- `busy` out 1: state is not IDLE.
- `timeout_err` out 1: one-cycle pulse when the WAIT_DONE watchdog expires.

## Operation
- **Pending register.**
  - Each edge: `pending <= (pending & ~clr) | call`.
  - `clr` is the one-hot mask of the issued target when `service_done` is sampled in WAIT_DONE; otherwise 0.
  - If a call and a clear hit the same floor in the same cycle, the call wins and the bit stays set.
- **FSM states:** IDLE, SELECT, ISSUE, WAIT_DONE.
- **IDLE:** go to SELECT when `pending != 0`.
- **SELECT (one cycle):** register the target using this priority:
  - The pending bit at `cur_floor`, if set.
  - Otherwise, the nearest pending floor in direction `dir_up`.
  - Otherwise, the nearest pending floor in the opposite direction; `dir_up` toggles in the same cycle.
  - If `cur_floor` is 0 or greater than NUM_FLOORS: pick the lowest pending floor and set `dir_up`=1.
  - Then go to ISSUE.
- **ISSUE:**
  - Assert `target_valid`. `target_floor` stays stable until the handshake.
  - When `target_valid & target_ready` is sampled, go to WAIT_DONE.
  - New calls do not change the issued target.
- **WAIT_DONE:**
  - Keep `target_floor` registered internally; the output port reads 0.
  - The watchdog counter increments each cycle.
  - On `service_done`: clear that pending bit, reset the counter, go to IDLE.
  - If the counter reaches TIMEOUT: pulse `timeout_err`, keep the pending bit, go to IDLE.
- **Ignored pulses:** `service_done` outside WAIT_DONE is ignored.
- **Widths:** the watchdog counter is clog2(TIMEOUT+1) bits and never wraps.

## Timing
- **Reset values:** state IDLE, `pending`=0, `target_floor`=0, `target_valid`=0, `dir_up`=1, `busy`=0, `timeout_err`=0, watchdog=0.
- **Call to pending:** a call sampled at edge N appears in `pending` after edge N.
- **Call to target (from IDLE):** `target_valid` rises 3 edges after the call edge.
- **Handshake:** completes on the edge where valid and ready are both high. `target_valid` falls after that edge.
- **Service to re-issue:** `service_done` at edge M gives IDLE after M. If calls remain, SELECT after M+1 and ISSUE (`target_valid` high) after M+2.
- **Reset mid-operation:** `rst` at any edge returns all registers to reset values on that edge. It overrides simultaneous calls.

## Structure
- **Shared package `elevator_pkg`:**
  - FSM state enum.
  - `FLOOR_W`.
  - `FLOOR_NONE`=0.
  - Direction constants.
  - Also used by the car controller.
- **Sub-module `elevator_scan_pick`:** combinational. Inputs: `pending`, `cur_floor`, `dir_up`. Outputs: `pick_floor`, `pick_found`, `flip_dir`. Instantiated once and registered in SELECT.

## Test plan
- **Single call:** after reset, `cur_floor`=1, call floor 5 at edge 0 → `target_valid`=1, `target_floor`=5 after edge 3. With `target_ready`=1, `service_done` 4 cycles later → `pending`=0 and `busy`=0.
- **SCAN ordering:** `cur_floor`=3, `dir_up`=1, calls {2,6,4} in one cycle → issued order 4, 6, 2. `dir_up` flips to 0 when 2 is chosen.
- **Current-floor priority:** `cur_floor`=4, pending {4,7} → target 4 first, with no direction change.
- **Set/clear collision:** call floor 5 in the same cycle as `service_done` for target 5 → `pending[4]` stays 1 and floor 5 is re-issued.
- **Watchdog:** withhold `service_done` → `timeout_err` pulses 63 cycles after entering WAIT_DONE, the pending bit stays set, and the same target is re-issued.
- **Reset mid-operation:** `rst` asserted during ISSUE with `target_valid`=1 → all outputs return to reset values after that edge. A call in the same cycle is dropped.
